// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding, default LFSR tap masks per width,
// and the signature width common to the pattern generator and the MISR.
package bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int MISR_W = 4;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  function automatic logic [31:0] default_taps(input int w);
    case (w)
      8:       default_taps = 32'(TAPS_W8);
      16:      default_taps = 32'(TAPS_W16);
      default: default_taps = 32'(TAPS_W4);
    endcase
  endfunction

endpackage

// File: rtl/bist_tpg_if.sv
// Control/pattern bus of the BIST test pattern generator.
// master = sequencer side, slave = generator side.
interface bist_tpg_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             seed_load;
  logic [W-1:0]     seed;
  logic             start;
  logic [CNT_W-1:0] num_patterns;
  logic [W-1:0]     pat_out;
  logic             pat_valid;
  logic             misr_en;
  logic             busy;
  logic             done;

  modport master (
    output seed_load, seed, start, num_patterns,
    input  pat_out, pat_valid, misr_en, busy, done
  );

  modport slave (
    input  seed_load, seed, start, num_patterns,
    output pat_out, pat_valid, misr_en, busy, done
  );
endinterface

// File: rtl/bist_tpg_lfsr_core.sv
// Fibonacci LFSR with parallel load and step enable.
// BIST_TPG_ALL_ZERO_EN adds the all-zero state (de Bruijn, period 2^W).
module lfsr_core #(
  parameter int           W       = 4,
  parameter logic [W-1:0] TAPS    = 4'hC,
  parameter logic [W-1:0] RST_VAL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_seed,
  input  logic         i_step,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  logic         w_fb;

  always_comb begin
    w_fb = ^(r_q & TAPS);
`ifdef BIST_TPG_ALL_ZERO_EN
    // Flipping feedback when the low bits are zero splices 0 in after 100..0.
    w_fb = w_fb ^ (r_q[W-2:0] == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)         r_q <= RST_VAL;
    else if (i_load) r_q <= i_seed;
    else if (i_step) r_q <= {r_q[W-2:0], w_fb};
  end

  assign o_q = r_q;
endmodule

// File: rtl/bist_tpg.sv
// BIST test pattern generator: seeded LFSR run of num_patterns, with a
// CUT_LAT-delayed MISR enable. Optional macro: BIST_TPG_ALL_ZERO_EN.
module bist_tpg #(
  parameter int           W        = 4,
  parameter logic [W-1:0] TAPS     = 4'hC,
  parameter logic [W-1:0] SEED_RST = 1,
  parameter int           CNT_W    = 8,
  parameter int           CUT_LAT  = 1
) (
  input logic        clk,
  input logic        rst,
  bist_tpg_if.slave  bus
);
  import bist_pkg::*;

  localparam logic [2:0] DRAIN_LAST = (CUT_LAT == 0) ? 3'd0 : 3'(CUT_LAT - 1);

  state_e           r_state;
  logic [W-1:0]     r_seed;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_dcnt;
  logic             w_idle, w_seed_wr, w_start, w_step, w_pv;
  logic [W-1:0]     w_seed_in, w_seed_eff;

  assign w_idle    = (r_state == IDLE) || (r_state == DONE);
  assign w_seed_wr = bus.seed_load && w_idle;
`ifdef BIST_TPG_ALL_ZERO_EN
  assign w_seed_in = bus.seed;
`else
  // A zero seed would lock the plain LFSR at zero.
  assign w_seed_in = (bus.seed == '0) ? W'(1) : bus.seed;
`endif
  // Same-cycle seed_load + start uses the freshly written seed.
  assign w_seed_eff = w_seed_wr ? w_seed_in : r_seed;
  assign w_start    = bus.start && w_idle && (bus.num_patterns != '0);
  // Final pattern is held so pat_out keeps it through DRAIN/DONE.
  assign w_step     = (r_state == RUN) && (r_cnt != '0);
  assign w_pv       = (r_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_seed  <= SEED_RST;
      r_cnt   <= '0;
      r_dcnt  <= '0;
    end else begin
      if (w_seed_wr) r_seed <= w_seed_in;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.num_patterns != '0) begin
              r_state <= RUN;
              r_cnt   <= bus.num_patterns - 1'b1;
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (r_cnt == '0) begin
            r_state <= (CUT_LAT == 0) ? DONE : DRAIN;
            r_dcnt  <= DRAIN_LAST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (r_dcnt == '0) r_state <= DONE;
          else              r_dcnt  <= r_dcnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  lfsr_core #(.W(W), .TAPS(TAPS), .RST_VAL(SEED_RST)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start),
    .i_seed (w_seed_eff),
    .i_step (w_step),
    .o_q    (bus.pat_out)
  );

  generate
    if (CUT_LAT == 0) begin : g_nodly
      assign bus.misr_en = w_pv;
    end else begin : g_dly
      logic [CUT_LAT-1:0] r_dly;
      always_ff @(posedge clk) begin
        if (rst) r_dly <= '0;
        else     r_dly <= CUT_LAT'({r_dly, w_pv});
      end
      assign bus.misr_en = r_dly[CUT_LAT-1];
    end
  endgenerate

  assign bus.pat_valid = w_pv;
  assign bus.busy      = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done      = (r_state == DONE);
endmodule

// File: tb/tb_bist_tpg.sv
// Directed bench for bist_tpg (W=4, TAPS=C, CUT_LAT=1); the zero-state
// section only runs when BIST_TPG_ALL_ZERO_EN is defined.
module tb_bist_tpg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  bist_tpg_if #(.W(4), .CNT_W(8)) bus ();

  bist_tpg #(.W(4), .TAPS(4'hC), .SEED_RST(4'h1), .CNT_W(8), .CUT_LAT(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_pv"},   32'(bus.pat_valid), 32'd0);
    chk({tag, "_men"},  32'(bus.misr_en),   32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),      32'd0);
    chk({tag, "_done"}, 32'(bus.done),      32'(exp_done));
  endtask

  initial begin
    bus.seed_load = 0; bus.seed = '0; bus.start = 0; bus.num_patterns = '0;
    step(); step();
    chk("rst_pat", 32'(bus.pat_out), 32'h1);
    chk_idle("rst", 1'b0);
    rst = 0;

    // 1: seed 1, five patterns, misr_en one cycle behind, done after drain
    bus.seed_load = 1; bus.seed = 4'h1; step(); bus.seed_load = 0;
    bus.start = 1; bus.num_patterns = 8'd5; step(); bus.start = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_pv%0d", i),  32'(bus.pat_valid), 32'd1);
      chk($sformatf("t1_pat%0d", i), 32'(bus.pat_out),   32'(seq[i]));
      chk($sformatf("t1_men%0d", i), 32'(bus.misr_en),   (i > 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("t1_drain_pv", 32'(bus.pat_valid), 32'd0);
    chk("t1_drain_men", 32'(bus.misr_en), 32'd1);
    chk("t1_drain_busy", 32'(bus.busy), 32'd1);
    chk("t1_drain_done", 32'(bus.done), 32'd0);
    step();
    chk_idle("t1_done", 1'b1);

`ifndef BIST_TPG_ALL_ZERO_EN
    // 2: zero seed written with start in the same cycle -> guard to 1, wraps after 15
    bus.seed_load = 1; bus.seed = 4'h0; bus.start = 1; bus.num_patterns = 8'd20;
    step(); bus.seed_load = 0; bus.start = 0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t2_pat%0d", i), 32'(bus.pat_out), 32'(seq[i % 15]));
      chk($sformatf("t2_pv%0d", i),  32'(bus.pat_valid), 32'd1);
      step();
    end
    chk("t2_drain_pv", 32'(bus.pat_valid), 32'd0);
    step();
    chk("t2_done", 32'(bus.done), 32'd1);
`endif

    // 3: zero-length run from IDLE goes straight to DONE
    rst = 1; step(); rst = 0;
    chk_idle("t3_pre", 1'b0);
    bus.start = 1; bus.num_patterns = 8'd0; step(); bus.start = 0;
    chk_idle("t3_done", 1'b1);
    step();
    chk_idle("t3_hold", 1'b1);

    // 4: start/seed_load during RUN are ignored
    bus.start = 1; bus.num_patterns = 8'd4; step(); bus.start = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_pat%0d", i), 32'(bus.pat_out), 32'(seq[i]));
      chk($sformatf("t4_pv%0d", i),  32'(bus.pat_valid), 32'd1);
      if (i == 0) begin
        bus.start = 1; bus.num_patterns = 8'd9; bus.seed_load = 1; bus.seed = 4'h7;
      end
      step();
      bus.start = 0; bus.seed_load = 0;
    end
    chk("t4_drain_pv", 32'(bus.pat_valid), 32'd0);
    chk("t4_drain_busy", 32'(bus.busy), 32'd1);
    step();
    chk("t4_done", 32'(bus.done), 32'd1);
    bus.start = 1; bus.num_patterns = 8'd2; step(); bus.start = 0;
    chk("t4_rerun_pat0", 32'(bus.pat_out), 32'h1);
    chk("t4_rerun_done", 32'(bus.done), 32'd0);
    step();
    chk("t4_rerun_pat1", 32'(bus.pat_out), 32'h2);
    step(); step();
    chk("t4_rerun_fin", 32'(bus.done), 32'd1);

    // 5: reset in the third RUN cycle aborts with no leaked capture
    bus.start = 1; bus.num_patterns = 8'd10; step(); bus.start = 0;
    step(); step();
    chk("t5_pre_pat", 32'(bus.pat_out), 32'h4);
    rst = 1; step();
    chk("t5_rst_pat", 32'(bus.pat_out), 32'h1);
    chk_idle("t5_rst", 1'b0);
    rst = 0; step();
    chk_idle("t5_after", 1'b0);

`ifdef BIST_TPG_ALL_ZERO_EN
    // 6: de Bruijn extension includes 0000 after 1000
    begin
      logic [3:0] db [3] = '{4'h8, 4'h0, 4'h1};
      logic [15:0] seen = '0;
      int dup = 0;
      bus.seed_load = 1; bus.seed = 4'h8; bus.start = 1; bus.num_patterns = 8'd3;
      step(); bus.seed_load = 0; bus.start = 0;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t6_pat%0d", i), 32'(bus.pat_out), 32'(db[i]));
        step();
      end
      step();
      bus.seed_load = 1; bus.seed = 4'h1; bus.start = 1; bus.num_patterns = 8'd16;
      step(); bus.seed_load = 0; bus.start = 0;
      for (int i = 0; i < 16; i++) begin
        if (seen[bus.pat_out]) dup++;
        seen[bus.pat_out] = 1'b1;
        step();
      end
      chk("t6_cover", 32'(seen), 32'hFFFF);
      chk("t6_dup", 32'(dup), 32'd0);
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
